// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Pure declarations and helper functions, no state.
// No flow control of its own.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {IDLE = 1'b0, RSP = 1'b1} state_t;

  // Lane mask for an access of the size encoded in funct3[1:0] at byte offset off.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'd1:    mis = off[0];
      2'd2:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // funct3 codes that name no legal load/store.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Aligns a loaded word to its byte offset and sign/zero-extends it.
// Purely combinational, zero latency.
// No backpressure; output follows inputs.
module mem_access_unit_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_off, 3'b000};

  // Extend the low byte/half of the shifted word according to the access type.
  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_data = {24'h0, w_shift[7:0]};
      F3_HU:   o_data = {16'h0, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-outstanding valid/ready data-memory access, MEM/WB registers.
// Latency: 1 cycle for non-access/error; stores 1 + ready-low cycles; loads >= 2 cycles.
// Stalls the upstream pipeline (memStall) while a request waits for ready or a load waits for data.
module mem_access_unit
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] aluResult,
  input  logic [31:0] aluOperand2,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        memStall,
  output logic [31:0] aluResultOut,
  output logic [31:0] memDataOut,
  output logic [4:0]  rdOut,
  output logic        memToRegOut,
  output logic        regWriteOut,
  output logic        accessErrOut
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_off;
  logic        w_access;
  logic        w_err;
  logic        w_ok_access;
  logic        w_load_done;
  logic [31:0] w_load_data;

  logic [31:0] r_alu;
  logic [31:0] r_mdata;
  logic [4:0]  r_rd;
  logic        r_m2r;
  logic        r_rwe;
  logic        r_err;

  assign w_off       = aluResult[1:0];
  assign w_access    = memRead | memWrite;
  assign w_err       = w_access & (misaligned(funct3, w_off) | f3_illegal(funct3) | (memRead & memWrite));
  assign w_ok_access = w_access & ~w_err;
  assign w_load_done = (r_state == RSP) & dmem_rsp_valid;

  // Request fields derive only from EX/MEM, which is frozen while stalled, so they hold under !ready.
  assign dmem_addr = {aluResult[31:2], 2'b00};
  assign dmem_we   = memWrite;
  assign dmem_be   = be_gen(funct3, w_off);

  // Replicate store data across every lane it may land in.
  always_comb begin
    case (funct3[1:0])
      2'd0:    dmem_wdata = {4{aluOperand2[7:0]}};
      2'd1:    dmem_wdata = {2{aluOperand2[15:0]}};
      default: dmem_wdata = aluOperand2;
    endcase
  end

  mem_access_unit_load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_off    (w_off),
    .i_funct3 (funct3),
    .o_data   (w_load_data)
  );

  // State register; reset abandons any in-flight load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state: accepted load waits in RSP for its response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ok_access & memRead & dmem_req_ready) w_next = RSP;
      RSP:     if (dmem_rsp_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: request only from IDLE; stall until the access completes.
  always_comb begin
    dmem_req_valid = 1'b0;
    memStall       = 1'b0;
    case (r_state)
      IDLE: begin
        dmem_req_valid = w_ok_access;
        memStall       = w_ok_access & ~(memWrite & dmem_req_ready);
      end
      RSP: begin
        memStall = ~dmem_rsp_valid;
      end
      default: begin
        dmem_req_valid = 1'b0;
        memStall       = 1'b0;
      end
    endcase
  end

  // MEM/WB register: stage result when not stalled, bubble otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_alu   <= '0;
      r_mdata <= '0;
      r_rd    <= '0;
      r_m2r   <= 1'b0;
      r_rwe   <= 1'b0;
      r_err   <= 1'b0;
    end else if (memStall) begin
      r_alu   <= '0;
      r_mdata <= '0;
      r_rd    <= '0;
      r_m2r   <= 1'b0;
      r_rwe   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_alu   <= aluResult;
      r_mdata <= w_load_done ? w_load_data : 32'h0;
      r_rd    <= rd;
      r_m2r   <= memToReg & ~w_err;
      r_rwe   <= regWrite & ~w_err;
      r_err   <= w_err;
    end
  end

  assign aluResultOut = r_alu;
  assign memDataOut   = r_mdata;
  assign rdOut        = r_rd;
  assign memToRegOut  = r_m2r;
  assign regWriteOut  = r_rwe;
  assign accessErrOut = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        resetn;
  logic [31:0] aluResult, aluOperand2, dmem_rdata;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        memRead, memWrite, memToReg, regWrite;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid, memStall;
  logic [31:0] dmem_addr, dmem_wdata, aluResultOut, memDataOut;
  logic [3:0]  dmem_be;
  logic [4:0]  rdOut;
  logic        memToRegOut, regWriteOut, accessErrOut;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit dut (
    .clk(clk), .resetn(resetn),
    .aluResult(aluResult), .aluOperand2(aluOperand2), .rd(rd), .funct3(funct3),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .memStall(memStall), .aluResultOut(aluResultOut), .memDataOut(memDataOut),
    .rdOut(rdOut), .memToRegOut(memToRegOut), .regWriteOut(regWriteOut),
    .accessErrOut(accessErrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] op2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          waits;
    int          lat;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] op2,
                              input logic [31:0] rdata, input int waits, input int lat,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] dat, input logic err);
    txn_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.addr = addr; t.op2 = op2; t.rdata = rdata;
    t.rd = 5'd7; t.waits = waits; t.lat = lat;
    t.exp_be = be; t.exp_wdata = wd; t.exp_data = dat; t.exp_err = err;
    return t;
  endfunction

  // Reference: byte-level view of memory access rules.
  function automatic void model(inout txn_t t);
    int size, off;
    longint val;
    logic [7:0] b;
    size = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(t.addr % 4);
    t.exp_err = (t.ld || t.st) &&
                ((off % size) != 0 || t.f3 == 3'd3 || t.f3 == 3'd6 || t.f3 == 3'd7 || (t.ld && t.st));
    t.exp_be = '0;
    t.exp_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) t.exp_be[i] = 1'b1;
      b = 8'(t.op2 >> (8 * (i % size)));
      t.exp_wdata = t.exp_wdata | (32'(b) << (8 * i));
    end
    val = 0;
    for (int i = 0; i < size; i++) begin
      if (off + i < 4) begin
        b = 8'(t.rdata >> (8 * (off + i)));
        val = val + (longint'(b) << (8 * i));
      end
    end
    if (t.f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
      val = val - (longint'(1) << (8 * size));
    t.exp_data = 32'(val);
  endfunction

  // Drive one EX/MEM instruction starting at a negedge; returns at a negedge after MEM/WB is checked.
  task automatic run_txn(input txn_t t);
    logic rwe;
    rwe = !t.st;
    aluResult = t.addr; aluOperand2 = t.op2; funct3 = t.f3; rd = t.rd;
    memRead = t.ld; memWrite = t.st; memToReg = t.ld; regWrite = rwe;
    dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
    dmem_req_ready = (t.waits == 0);
    #1;
    if (t.exp_err || !(t.ld || t.st)) begin
      chk("noacc_req_valid", 32'(dmem_req_valid), 0);
      chk("noacc_stall", 32'(memStall), 0);
      @(negedge clk);
      chk("noacc_err", 32'(accessErrOut), 32'(t.exp_err));
      chk("noacc_rwe", 32'(regWriteOut), 32'(rwe && !t.exp_err));
      chk("noacc_m2r", 32'(memToRegOut), 0);
      chk("noacc_alu", aluResultOut, t.addr);
      chk("noacc_mdata", memDataOut, 0);
      return;
    end
    for (int w = 0; w < t.waits; w++) begin
      chk("wait_req_valid", 32'(dmem_req_valid), 1);
      chk("wait_stall", 32'(memStall), 1);
      chk("wait_addr", dmem_addr, {t.addr[31:2], 2'b00});
      chk("wait_be", 32'(dmem_be), 32'(t.exp_be));
      @(negedge clk);
      chk("wait_bubble_rwe", 32'(regWriteOut), 0);
      chk("wait_bubble_rd", 32'(rdOut), 0);
      dmem_req_ready = (w == t.waits - 1);
      #1;
    end
    chk("req_valid", 32'(dmem_req_valid), 1);
    chk("req_addr", dmem_addr, {t.addr[31:2], 2'b00});
    chk("req_be", 32'(dmem_be), 32'(t.exp_be));
    chk("req_we", 32'(dmem_we), 32'(t.st));
    if (t.st) begin
      chk("st_wdata", dmem_wdata, t.exp_wdata);
      chk("st_stall", 32'(memStall), 0);
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("st_rwe", 32'(regWriteOut), 0);
      chk("st_err", 32'(accessErrOut), 0);
      chk("st_alu", aluResultOut, t.addr);
      return;
    end
    chk("ld_accept_stall", 32'(memStall), 1);
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("ld_accept_bubble", 32'(regWriteOut), 0);
    for (int i = 1; i < t.lat; i++) begin
      #1;
      chk("rsp_req_valid", 32'(dmem_req_valid), 0);
      chk("rsp_stall", 32'(memStall), 1);
      @(negedge clk);
      chk("rsp_bubble", 32'(regWriteOut), 0);
    end
    dmem_rsp_valid = 1'b1; dmem_rdata = t.rdata;
    #1;
    chk("ld_done_stall", 32'(memStall), 0);
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("ld_data", memDataOut, t.exp_data);
    chk("ld_rwe", 32'(regWriteOut), 1);
    chk("ld_m2r", 32'(memToRegOut), 1);
    chk("ld_rd", 32'(rdOut), 32'(t.rd));
    chk("ld_err", 32'(accessErrOut), 0);
  endtask

  task automatic idle_inputs();
    memRead = 0; memWrite = 0; memToReg = 0; regWrite = 0;
    aluResult = 0; aluOperand2 = 0; rd = 0; funct3 = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
  endtask

  txn_t tbl[12];
  txn_t rt;

  initial begin
    tbl[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 0);
    tbl[1]  = mk(0, 1, 3'd0, 32'h103, 32'h000000AB, 0, 0, 1, 4'b1000, 32'hABABABAB, 0, 0);
    tbl[2]  = mk(1, 0, 3'd0, 32'h102, 0, 32'h12F45678, 0, 2, 4'b0100, 0, 32'hFFFFFFF4, 0);
    tbl[3]  = mk(1, 0, 3'd4, 32'h102, 0, 32'h12F45678, 0, 2, 4'b0100, 0, 32'h000000F4, 0);
    tbl[4]  = mk(1, 0, 3'd1, 32'h101, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 3'd2, 32'h200, 0, 32'hCAFEF00D, 3, 1, 4'b1111, 0, 32'hCAFEF00D, 0);
    tbl[6]  = mk(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 0, 1, 1, 4'b1100, 32'hABCDABCD, 0, 0);
    tbl[7]  = mk(1, 0, 3'd5, 32'h102, 0, 32'h87654321, 0, 1, 4'b1100, 0, 32'h00008765, 0);
    tbl[8]  = mk(1, 0, 3'd1, 32'h102, 0, 32'h87654321, 1, 3, 4'b1100, 0, 32'hFFFF8765, 0);
    tbl[9]  = mk(0, 0, 3'd3, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 3'd3, 32'h40, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[11] = mk(1, 1, 3'd2, 32'h40, 0, 0, 0, 1, 0, 0, 0, 1);

    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(memStall), 0);
    chk("rst_req_valid", 32'(dmem_req_valid), 0);
    chk("rst_alu", aluResultOut, 0);
    chk("rst_mdata", memDataOut, 0);
    chk("rst_flags", {27'h0, rdOut} | 32'({memToRegOut, regWriteOut, accessErrOut}), 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Response while idle must not leak into MEM/WB.
    idle_inputs();
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("idle_rsp_stall", 32'(memStall), 0);
    @(negedge clk);
    chk("idle_rsp_mdata", memDataOut, 0);
    dmem_rsp_valid = 1'b0;

    // Reset while a load is outstanding, then a stale response.
    aluResult = 32'h300; funct3 = 3'd2; memRead = 1; memToReg = 1; regWrite = 1; rd = 5'd9;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    chk("mid_rsp_stall", 32'(memStall), 1);
    idle_inputs();
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(memStall), 0);
    chk("mid_rst_req", 32'(dmem_req_valid), 0);
    chk("mid_rst_rwe", 32'(regWriteOut), 0);
    @(negedge clk);
    resetn = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5A5A5A5A;
    #1;
    chk("late_rsp_stall", 32'(memStall), 0);
    @(negedge clk);
    chk("late_rsp_mdata", memDataOut, 0);
    dmem_rsp_valid = 1'b0;
    run_txn(tbl[5]);

    // Randomized traffic against the byte-level model.
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 19));
      rt.ld    = (kind < 9) || (kind == 19);
      rt.st    = (kind >= 9 && kind < 17) || (kind == 19);
      rt.f3    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'({$urandom_range(0, 1), 2'($urandom_range(0, 2))});
      rt.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) rt.addr[0] = 1'b0;
      if ($urandom_range(0, 2) != 0 && rt.f3[1:0] == 2'd2) rt.addr[1] = 1'b0;
      rt.op2   = $urandom;
      rt.rdata = $urandom;
      rt.rd    = 5'($urandom_range(1, 31));
      rt.waits = int'($urandom_range(0, 2));
      rt.lat   = int'($urandom_range(1, 3));
      model(rt);
      run_txn(rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
